// File: rtl/sg_pkg.sv
// sg_pkg: shared constants and types for the Savitzky-Golay windowing stage
// and the downstream fitter.
//   WINDOW_SIZE / HALF : samples per window and samples either side of centre
//   DATA_W             : signed sample width
//   FRAME_MAX / IDX_W  : largest supported frame and width of a centre index
//   CNT_W              : width of the internal frame counters (wider than IDX_W
//                        so the emission threshold still works past FRAME_MAX)
//   sample_t           : one signed sample
//   win_state_t        : windowing FSM states
package sg_pkg;
  localparam int WINDOW_SIZE = 7;
  localparam int HALF        = WINDOW_SIZE / 2;
  localparam int DATA_W      = 32;
  localparam int FRAME_MAX   = 1024;
  localparam int IDX_W       = $clog2(FRAME_MAX);
  localparam int CNT_W       = 32;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } win_state_t;
endpackage

// File: rtl/sg_shift_window.sv
// sg_shift_window: WINDOW_SIZE-deep sample register array.
//   clk, rst  : clock, asynchronous active-low reset (clears every entry)
//   load_all  : write din into every entry (first sample of a frame)
//   shift_en  : shift towards entry 0, din enters at entry WINDOW_SIZE-1
//   din       : incoming sample
//   window    : flat view, slice j = entry j (entry 0 is the oldest)
module sg_shift_window
  import sg_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_all,
  input  logic                          shift_en,
  input  sample_t                       din,
  output logic [WINDOW_SIZE*DATA_W-1:0] window
);

  sample_t taps_reg [WINDOW_SIZE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WINDOW_SIZE; i++) taps_reg[i] <= '0;
    end else if (load_all) begin
      for (int i = 0; i < WINDOW_SIZE; i++) taps_reg[i] <= din;
    end else if (shift_en) begin
      for (int i = 0; i < WINDOW_SIZE - 1; i++) taps_reg[i] <= taps_reg[i+1];
      taps_reg[WINDOW_SIZE-1] <= din;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WINDOW_SIZE; gi++) begin : g_flat
      assign window[gi*DATA_W +: DATA_W] = taps_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/sg_window_buffer.sv
// sg_window_buffer: turns a sample stream into one centred, edge-replicated
// window per input sample for the Savitzky-Golay fitter.
//   clk, rst                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   : sample input handshake
//   in_last                     : final sample of the frame
//   out_valid/out_ready         : window output handshake
//   out_window                  : WINDOW_SIZE samples, slice 0 oldest
//   out_center_idx              : frame index of the window centre
//   out_last                    : window for the final sample
//   overrun                     : sticky, a frame exceeded FRAME_MAX samples
module sg_window_buffer
  import sg_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WINDOW_SIZE*DATA_W-1:0] out_window,
  output logic [IDX_W-1:0]              out_center_idx,
  output logic                          out_last,
  output logic                          overrun
);

  win_state_t       state_reg;
  logic [CNT_W-1:0] shifts_reg;
  logic [CNT_W-1:0] emitted_reg;
  logic [CNT_W-1:0] n_len_reg;
  logic             out_valid_reg;
  logic [IDX_W-1:0] center_reg;
  logic             last_reg;
  logic             overrun_reg;

  logic             out_free;
  logic             accept;
  logic             load_all;
  logic             flush_shift;
  logic             shift_en;
  logic             step;
  logic             emit;
  logic             final_emit;
  logic [CNT_W-1:0] shifts_next;
  sample_t          din;

  // The window register only moves when the current output is absent or is
  // being consumed, so it can drive out_window directly and stays frozen
  // under backpressure.
  assign out_free    = !out_valid_reg || out_ready;
  assign in_ready    = rst && (state_reg != FLUSH) && out_free;
  assign accept      = in_valid && in_ready;
  assign load_all    = accept && (state_reg == IDLE);
  assign flush_shift = (state_reg == FLUSH) && out_free;
  assign shift_en    = (accept && (state_reg == STREAM)) || flush_shift;
  assign step        = load_all || shift_en;
  assign shifts_next = load_all ? CNT_W'(1) : shifts_reg + CNT_W'(1);
  assign emit        = step && (shifts_next >= CNT_W'(HALF + 1));
  assign final_emit  = flush_shift && emit && (emitted_reg + CNT_W'(1) == n_len_reg);

  // During flush the newest entry already holds the frame's last sample,
  // so replicating it needs no separate register.
  assign din = (state_reg == FLUSH) ? sample_t'(out_window[(WINDOW_SIZE-1)*DATA_W +: DATA_W])
                                    : sample_t'(in_data);

  sg_shift_window u_window (
    .clk      (clk),
    .rst      (rst),
    .load_all (load_all),
    .shift_en (shift_en),
    .din      (din),
    .window   (out_window)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      shifts_reg    <= '0;
      emitted_reg   <= '0;
      n_len_reg     <= '0;
      out_valid_reg <= 1'b0;
      center_reg    <= '0;
      last_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (step) begin
        out_valid_reg <= emit;
        if (emit) begin
          center_reg <= IDX_W'(shifts_next - CNT_W'(1 + HALF));
          last_reg   <= final_emit;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (accept && (shifts_next == CNT_W'(FRAME_MAX + 1))) overrun_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (load_all) begin
            shifts_reg <= shifts_next;
            if (in_last) begin
              n_len_reg <= shifts_next;
              state_reg <= FLUSH;
            end else begin
              state_reg <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            shifts_reg <= shifts_next;
            if (emit) emitted_reg <= emitted_reg + CNT_W'(1);
            if (in_last) begin
              n_len_reg <= shifts_next;
              state_reg <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_shift) begin
            if (final_emit) begin
              state_reg   <= IDLE;
              shifts_reg  <= '0;
              emitted_reg <= '0;
              n_len_reg   <= '0;
            end else begin
              shifts_reg <= shifts_next;
              if (emit) emitted_reg <= emitted_reg + CNT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_center_idx = center_reg;
  assign out_last       = last_reg;
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_sg_window_buffer.sv
module tb_sg_window_buffer;
  import sg_pkg::*;

  localparam int WD = WINDOW_SIZE * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WD-1:0]     out_window;
  logic [IDX_W-1:0]  out_center_idx;
  logic              out_last;
  logic              overrun;

  always #5 clk = ~clk;

  sg_window_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_window     (out_window),
    .out_center_idx (out_center_idx),
    .out_last       (out_last),
    .overrun        (overrun)
  );

  typedef struct {
    logic [WD-1:0]    win;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   frame[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pop_cnt = 0;
  int   acc_cnt = 0;
  logic valid_after [0:1099];
  logic ovr_after   [0:1099];

  // Scoreboard: every consumed window is matched against the model queue.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_window: got idx=%0d last=%0b, required no window", out_center_idx, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        pop_cnt++;
        if (out_window !== mon_e.win || out_center_idx !== mon_e.idx || out_last !== mon_e.last) begin
          n_err++;
          $display("FAIL window: got idx=%0d last=%0b win=%h, required idx=%0d last=%0b win=%h",
                   out_center_idx, out_last, out_window, mon_e.idx, mon_e.last, mon_e.win);
        end else begin
          $display("window idx=%0d last=%0b ok", out_center_idx, out_last);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: replicate-padded window around each centre of the frame.
  task automatic push_expected();
    int n = frame.size();
    for (int c = 0; c < n; c++) begin
      exp_t e;
      for (int j = 0; j < WINDOW_SIZE; j++) begin
        int k = c + j - HALF;
        if (k < 0) k = 0;
        if (k > n - 1) k = n - 1;
        e.win[j*DATA_W +: DATA_W] = frame[k];
      end
      e.idx  = IDX_W'(c);
      e.last = (c == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Sends the first n_send samples of frame; in_last only on the true last one.
  task automatic drive(input int n_send);
    int n = frame.size();
    for (int i = 0; i < n_send; i++) begin
      logic acc = 1'b0;
      int guard = 0;
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = (i == n - 1);
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: sample %0d not accepted, required accept within 200 cycles", i);
        break;
      end
      valid_after[acc_cnt] = out_valid;
      ovr_after[acc_cnt]   = overrun;
      acc_cnt++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({out_valid, out_last, overrun, in_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got valid/last/ovr/ready=%b, required 0000", {out_valid, out_last, overrun, in_ready});
    end
    n_vec++;
    if (out_window !== '0 || out_center_idx !== '0) begin
      n_err++;
      $display("FAIL reset_data: got idx=%0d win=%h, required 0", out_center_idx, out_window);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("reset released");
  endtask

  task automatic test_ramp();
    bit ok;
    frame.delete();
    for (int i = 0; i < 10; i++) frame.push_back(i);
    pop_cnt = 0;
    acc_cnt = 0;
    push_expected();
    drive(10);
    wait_drain(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ramp_drain: got %0d windows left, required 0", exp_q.size()); end
    n_vec++;
    if (pop_cnt !== 10) begin n_err++; $display("FAIL ramp_count: got %0d, required 10", pop_cnt); end
    n_vec++;
    if (valid_after[2] !== 1'b0) begin n_err++; $display("FAIL ramp_early_valid: got %b after 3rd accept, required 0", valid_after[2]); end
    n_vec++;
    if (valid_after[3] !== 1'b1) begin n_err++; $display("FAIL ramp_first_valid: got %b after 4th accept, required 1", valid_after[3]); end
  endtask

  task automatic test_single();
    bit ok;
    frame.delete();
    frame.push_back(42);
    pop_cnt = 0;
    push_expected();
    drive(1);
    wait_drain(ok);
    n_vec++;
    if (!ok || pop_cnt !== 1) begin n_err++; $display("FAIL single: got %0d windows drained=%0b, required 1 drained=1", pop_cnt, ok); end
  endtask

  task automatic test_two();
    bit ok;
    frame.delete();
    frame.push_back(5);
    frame.push_back(6);
    pop_cnt = 0;
    push_expected();
    drive(2);
    wait_drain(ok);
    n_vec++;
    if (!ok || pop_cnt !== 2) begin n_err++; $display("FAIL two: got %0d windows drained=%0b, required 2 drained=1", pop_cnt, ok); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    pop_cnt = 0;
    frame.delete();
    for (int i = 1; i <= 3; i++) frame.push_back(i * 11);
    push_expected();
    drive(3);
    frame.delete();
    frame.push_back(-7);
    frame.push_back(-8);
    push_expected();
    drive(2);
    wait_drain(ok);
    n_vec++;
    if (!ok || pop_cnt !== 5) begin n_err++; $display("FAIL back_to_back: got %0d windows drained=%0b, required 5 drained=1", pop_cnt, ok); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [WD-1:0] hold;
    frame.delete();
    for (int i = 0; i < 16; i++) frame.push_back(200 + i);
    pop_cnt = 0;
    acc_cnt = 0;
    push_expected();
    fork
      drive(16);
      begin
        int g = 0;
        while (acc_cnt < 8 && g < 500) begin
          @(posedge clk);
          #1;
          g++;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) hold = out_window;
          n_vec++;
          if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b at stall cycle %0d, required 1", out_valid, k); end
          n_vec++;
          if (out_window !== hold) begin n_err++; $display("FAIL stall_window: got %h at stall cycle %0d, required %h", out_window, k, hold); end
          n_vec++;
          if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b at stall cycle %0d, required 0", in_ready, k); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain(ok);
    n_vec++;
    if (!ok || pop_cnt !== 16) begin n_err++; $display("FAIL backpressure: got %0d windows drained=%0b, required 16 drained=1", pop_cnt, ok); end
  endtask

  task automatic test_midreset();
    bit ok;
    frame.delete();
    for (int i = 0; i < 20; i++) frame.push_back(300 + i);
    push_expected();
    drive(6);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_last, overrun, in_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_flags: got valid/last/ovr/ready=%b, required 0000", {out_valid, out_last, overrun, in_ready});
    end
    n_vec++;
    if (out_window !== '0 || out_center_idx !== '0) begin
      n_err++;
      $display("FAIL midreset_data: got idx=%0d win=%h, required 0", out_center_idx, out_window);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    frame.delete();
    for (int i = 100; i <= 104; i++) frame.push_back(i);
    pop_cnt = 0;
    push_expected();
    drive(5);
    wait_drain(ok);
    n_vec++;
    if (!ok || pop_cnt !== 5) begin n_err++; $display("FAIL after_reset_frame: got %0d windows drained=%0b, required 5 drained=1", pop_cnt, ok); end
  endtask

  task automatic test_overrun();
    bit ok;
    frame.delete();
    for (int i = 0; i < FRAME_MAX + 1; i++) frame.push_back(i * 3 - 500);
    pop_cnt = 0;
    acc_cnt = 0;
    push_expected();
    drive(FRAME_MAX + 1);
    n_vec++;
    if (ovr_after[FRAME_MAX-1] !== 1'b0) begin n_err++; $display("FAIL overrun_early: got %b after accept %0d, required 0", ovr_after[FRAME_MAX-1], FRAME_MAX); end
    n_vec++;
    if (ovr_after[FRAME_MAX] !== 1'b1) begin n_err++; $display("FAIL overrun_rise: got %b after accept %0d, required 1", ovr_after[FRAME_MAX], FRAME_MAX + 1); end
    wait_drain(ok);
    n_vec++;
    if (!ok || pop_cnt !== FRAME_MAX + 1) begin n_err++; $display("FAIL overrun_frame: got %0d windows drained=%0b, required %0d drained=1", pop_cnt, ok, FRAME_MAX + 1); end
    n_vec++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b, required 0", overrun); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_single();
    test_two();
    test_back_to_back();
    test_backpressure();
    test_midreset();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
